// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: word RAM behind the core's load/store port,
// completing each access LATENCY+1 cycles after accept and stalling the core meanwhile.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    op_wr, op_err;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [2**ADDR_WIDTH];

  logic                    req, req_err, commit;
  logic                    c_wr, c_err;
  logic [ADDR_WIDTH-1:0]   c_word;
  logic [31:0]             c_wdata;

  // Upper address bits only alias; they never select anything.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign req     = mem_read | mem_write;
  assign req_err = (addr[1:0] != 2'b00) | (mem_read & mem_write);

  // With zero latency the commit happens on the accept edge, so use live inputs.
  assign c_wr    = (state == IDLE) ? mem_write  : op_wr;
  assign c_err   = (state == IDLE) ? req_err    : op_err;
  assign c_word  = (state == IDLE) ? addr[ADDR_WIDTH+1:2] : word_q;
  assign c_wdata = (state == IDLE) ? write_data : wdata_q;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: if (req) begin
        stall = 1'b1;
        if (LATENCY == 0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  assign err   = (state == DONE) & op_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      op_err    <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        op_wr   <= mem_write;
        op_err  <= req_err;
        word_q  <= addr[ADDR_WIDTH+1:2];
        wdata_q <= write_data;
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !c_wr && !c_err)
        read_data <= mem[c_word];
    end
  end

  // RAM is never cleared; reset only blocks a write that has not yet committed.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_wr && !c_err)
      mem[c_word] <= c_wdata;
  end

endmodule
